shift_add_multiplier: RTL and testbench

Sequential unsigned 5×5 multiplier that time-shares one 10-bit ripple-carry adder (`TenBitFullAdder`) over five add-and-shift iterations. It produces a 10-bit product under a start/ready/done handshake. It is the first control block built on top of the adder datapath and serves as the multiply unit for later course designs that cannot afford a combinational array multiplier.

---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/shift_add_multiplier_if.sv | 31 +++
 rtl/shift_add_multiplier_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 102 ++++++++++
 tb/tb_shift_add_multiplier.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared sizes, iteration count and FSM state type
// for the sequential shift-add multiplier.
package mult_pkg;

    localparam int OPERAND_W  = 5;
    localparam int PRODUCT_W  = 2 * OPERAND_W;
    localparam int ITERATIONS = 5;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/ready/done request bus between a client
// and the shift-add multiplier.
interface shift_add_multiplier_if;
    import mult_pkg::*;

    logic                 start;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic                 ready;
    logic                 done;
    logic [PRODUCT_W-1:0] product;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output done,
        output product
    );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// 10-bit ripple-carry adder used as the shared
// datapath of the shift-add multiplier.
module TenBitFullAdder (
    input  logic [9:0] a_i,
    input  logic [9:0] b_i,
    input  logic       cin_i,
    output logic [9:0] sum_o,
    output logic       cout_o
);

    logic [10:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 10; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i])
                            | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[10];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned 5x5 multiplier: five add-and-shift steps
// through one shared 10-bit ripple adder.
module shift_add_multiplier #(
    parameter int OPERAND_W = 5,
    parameter int PRODUCT_W = 10
) (
    input logic                   clk,
    input logic                   rst,
    shift_add_multiplier_if.slave bus
);
    import mult_pkg::*;

    if (PRODUCT_W != 2 * OPERAND_W || PRODUCT_W != 10
        || OPERAND_W != mult_pkg::OPERAND_W) begin : g_bad_width
        $error("shift_add_multiplier: product must be 10 bits");
    end

    mult_state_t          state_q, state_d;
    logic [PRODUCT_W-1:0] p_q, p_d;
    logic [PRODUCT_W-1:0] m_q, m_d;
    logic [OPERAND_W-1:0] q_q, q_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [PRODUCT_W-1:0] add_b;
    logic [PRODUCT_W-1:0] add_sum;
    logic                 add_cout;

    assign add_b = q_q[0] ? m_q : '0;

    TenBitFullAdder u_adder (
        .a_i    (p_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    p_d     = '0;
                    m_d     = {{(PRODUCT_W - OPERAND_W){1'b0}}, bus.a};
                    q_d     = bus.b;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                p_d   = add_sum;
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are held low while reset is applied.
    always_comb begin
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        if (!rst) begin
            bus.ready = (state_q == IDLE);
            bus.done  = (state_q == DONE);
        end
    end

    assign bus.product = p_q;

    // 31*31 fits in 10 bits, so the shared adder never carries out.
    a_no_carry: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == CALC) |-> !add_cout
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: vector table, corner sequences,
// exhaustive sweep and a latency-aware scoreboard.
module tb_shift_add_multiplier;
    import mult_pkg::*;

    logic clk;
    logic rst;

    shift_add_multiplier_if bus ();

    shift_add_multiplier #(
        .OPERAND_W (5),
        .PRODUCT_W (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        logic [9:0] prod;
        int         edge_no;
    } exp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         edge_cnt = 0;
    logic [9:0] last_prod = '0;
    exp_t       exp_q[$];
    vec_t       tbl[8];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Scoreboard push on every accepted request.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_prod = '0;
        end else if (bus.start === 1'b1 && bus.ready === 1'b1) begin
            exp_q.push_back('{prod: 10'(bus.a) * 10'(bus.b),
                              edge_no: edge_cnt});
        end
        edge_cnt = edge_cnt + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            check("done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_product", 32'(bus.product), 32'(e.prod));
                check("sb_latency", edge_cnt - e.edge_no, 6);
                last_prod = e.prod;
            end
        end
        if (bus.ready === 1'b1) begin
            check("idle_hold", 32'(bus.product), 32'(last_prod));
        end
        if (rst === 1'b0 && dut.state_q == CALC) begin
            check("adder_cout", 32'(dut.add_cout), 0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_in_time", 32'(n < 20), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 32'(n < 20), 1);
    endtask

    task automatic run_op(input logic [4:0] ai, input logic [4:0] bi);
        wait_ready();
        bus.a     = ai;
        bus.b     = bi;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 5'($urandom);
        bus.b     = 5'($urandom);
        wait_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int n_done;
        int last_done_edge;

        tbl[0] = '{a: 5'd5,  b: 5'd3,  exp: 10'd15};
        tbl[1] = '{a: 5'd31, b: 5'd31, exp: 10'd961};
        tbl[2] = '{a: 5'd0,  b: 5'd31, exp: 10'd0};
        tbl[3] = '{a: 5'd31, b: 5'd0,  exp: 10'd0};
        tbl[4] = '{a: 5'd1,  b: 5'd1,  exp: 10'd1};
        tbl[5] = '{a: 5'd7,  b: 5'd9,  exp: 10'd63};
        tbl[6] = '{a: 5'd20, b: 5'd25, exp: 10'd500};
        tbl[7] = '{a: 5'd16, b: 5'd30, exp: 10'd480};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready), 1);
        check("post_rst_done", 32'(bus.done), 0);
        check("post_rst_product", 32'(bus.product), 0);

        run_op(5'd5, 5'd3);
        check("first_product", 32'(bus.product), 15);
        @(negedge clk);
        check("ready_back", 32'(bus.ready), 1);
        check("done_one_cycle", 32'(bus.done), 0);

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d", i), 32'(bus.product), 32'(tbl[i].exp));
        end

        // start held high: back-to-back results every 7 cycles
        wait_ready();
        bus.a          = 5'd7;
        bus.b          = 5'd9;
        bus.start      = 1'b1;
        n_done         = 0;
        last_done_edge = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (n_done > 0) begin
                    check("held_spacing", edge_cnt - last_done_edge, 7);
                end
                last_done_edge = edge_cnt;
                n_done++;
                check("held_product", 32'(bus.product), 63);
            end
        end
        bus.start = 1'b0;
        check("held_count", n_done, 3);

        // start pulses while busy must be ignored
        wait_ready();
        bus.a     = 5'd3;
        bus.b     = 5'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 5'd31;
        bus.b     = 5'd31;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        check("busy_product", 32'(bus.product), 9);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("after_done_ready", 32'(bus.ready), 1);
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("busy_no_extra_done", n_done, 0);
        check("busy_hold", 32'(bus.product), 9);

        // reset in the third CALC cycle discards the operation
        wait_ready();
        bus.a     = 5'd20;
        bus.b     = 5'd25;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(dut.state_q == IDLE), 1);
        check("midrst_ready", 32'(bus.ready), 1);
        check("midrst_product", 32'(bus.product), 0);
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        run_op(5'd20, 5'd25);
        check("after_rst_product", 32'(bus.product), 500);

        for (int ai = 0; ai < 32; ai++) begin
            for (int bi = 0; bi < 32; bi++) begin
                run_op(5'(ai), 5'(bi));
                check("sweep", 32'(bus.product), 32'(ai * bi));
            end
        end

        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
